input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage ahead of the serial multiplier controller. Synchronizes the two active-low push-buttons and the 8 operand switches to `Clk`, debounces the buttons, and emits single-cycle `Run_pulse` / `Clear_pulse` strobes. It also holds a stable switch value for the B-register load. `Run_pulse` is gated by the controller's `Busy` so a press during a multiply is dropped rather than queued.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button change; legal range 2..2^20.
- `SW_WIDTH`, default 8: switch bus width.

- `Clk`  in  1  system clock.
- `Reset`  in  1  reset, synchronous and active-high.
- `Run_n_raw`  in  1  Run button, active-low, asynchronous, bouncy.
- `Clear_n_raw`  in  1  Reset_Load_Clear button, active-low, asynchronous, bouncy.
- `Sw_raw`  in  SW_WIDTH  operand switches, asynchronous.
- `Busy`  in  1  controller is mid-multiply (state is neither START nor HALT).
- `Run_pulse`  out  1  one-cycle strobe on an accepted Run press.
- `Clear_pulse`  out  1  one-cycle strobe on an accepted Clear press.
- `Run_level`, `Clear_level`  out  1  debounced pressed state, active-high.
- `Sw_sync`  out  SW_WIDTH  two-flop synchronized switches.
- `Sw_hold`  out  SW_WIDTH  `Sw_sync` captured on each `Clear_pulse`.

## Operation
- Per button: 2-flop synchronizer, then inverter giving internal `pressed`, then debouncer, then edge detector.
- Debouncer per button:
  - State: `stable` bit and counter, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `pressed == stable`, counter is cleared.
  - If they differ and counter < DEBOUNCE_CYCLES-1, counter increments.
  - If they differ and counter == DEBOUNCE_CYCLES-1, `stable <= pressed` and counter is cleared.
- Pulse generation:
  - A stable 0→1 edge registers the pulse for exactly one cycle.
  - A stable 1→0 edge (release) produces no pulse.
- Busy gating: if `Busy` is 1 at the edge where Run's `stable` rises, `Run_pulse` stays 0. The press is lost; the user must release and press again.
- Priority: if Run and Clear become stable-pressed at the same edge, `Clear_pulse`=1 and `Run_pulse`=0.
- `Clear_pulse` is never gated by `Busy`.
- `Sw_hold <= Sw_sync` at the same edge that sets `Clear_pulse`, so `Sw_hold` is valid in the cycle `Clear_pulse` is high.
- Holding a button never repeats a pulse; a new pulse requires an accepted release followed by an accepted press.
- Reset:
  - Synchronizers load the released value (1).
  - `stable`=0, counters=0.
  - All outputs 0: `Run_pulse`, `Clear_pulse`, `Run_level`, `Clear_level`, `Sw_sync`, `Sw_hold`.
  - Reset asserted mid-count discards the count; no pulse is produced.
  - A button held through reset release is accepted as a fresh press afterwards.

## Timing
- Let edge 0 be the first `Clk` edge that samples a clean raw press, with N = DEBOUNCE_CYCLES:
  - Synchronizer output valid after edge 1.
  - Counter = 1 after edge 2; reaches N-1 after edge N.
  - `stable` and `*_level` rise at edge N+1; `*_pulse` is high from edge N+1 to edge N+2.
- Release latency is also N+1 edges to `*_level` falling.
- Bounce: any synchronized sample equal to `stable` restarts the count, so acceptance needs N consecutive differing synchronized samples.
- `Sw_sync` latency: 2 edges. `Sw_hold` updates only at the `Clear_pulse` edge.
- `Busy` is sampled combinationally at the pulse-setting edge; no setup beyond the normal register path.

## Test plan
- Clean Run press, N=4, Busy=0, `Run_n_raw` low at edge 0 → `Run_level`=1 and `Run_pulse`=1 after edge 5, `Run_pulse`=0 after edge 6; holding 50 cycles produces no further pulse.
- Bounce, N=4: `Run_n_raw` toggles low/high/low/low/high then steady low → no pulse until 5 edges after the final steady-low sample; exactly one pulse.
- Busy gating: press while Busy=1 → `Run_pulse` never asserts; release, drop Busy, press again → one pulse.
- Clear with switches 0xA5: `Sw_raw`=0xA5, Clear pressed → `Clear_pulse` for 1 cycle with `Sw_hold`=0xA5; then change `Sw_raw` to 0x3C → `Sw_sync`=0x3C after 2 edges, `Sw_hold` stays 0xA5.
- Simultaneous press: both buttons low at the same edge → `Clear_pulse`=1, `Run_pulse`=0.
- Reset mid-count: assert `Reset` with the counter at 2 → no pulse, all outputs 0; button still held after reset releases → pulse N+1 edges later.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Button, switch and strobe bundle between the board-facing input stage and the
// multiplier controller side.
interface input_conditioner_if #(
    parameter int SW_WIDTH = 8
);
    logic                Run_n_raw;
    logic                Clear_n_raw;
    logic [SW_WIDTH-1:0] Sw_raw;
    logic                Busy;
    logic                Run_pulse;
    logic                Clear_pulse;
    logic                Run_level;
    logic                Clear_level;
    logic [SW_WIDTH-1:0] Sw_sync;
    logic [SW_WIDTH-1:0] Sw_hold;

    modport master (
        output Run_n_raw, Clear_n_raw, Sw_raw, Busy,
        input  Run_pulse, Clear_pulse, Run_level, Clear_level, Sw_sync, Sw_hold
    );

    modport slave (
        input  Run_n_raw, Clear_n_raw, Sw_raw, Busy,
        output Run_pulse, Clear_pulse, Run_level, Clear_level, Sw_sync, Sw_hold
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the Run/Clear push-buttons, emits single-cycle press
// strobes, and synchronizes/holds the operand switches for the B-register load.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 8
) (
    input logic                Clk,
    input logic                Reset,
    input_conditioner_if.slave bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is Run, bit 1 is Clear.
    logic [1:0]          raw_n;
    logic [1:0]          meta_n;
    logic [1:0]          sync_n;
    logic [1:0]          pressed;
    logic [1:0]          stable;
    logic [1:0]          rise;

    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [SW_WIDTH-1:0] sw_hold;
    logic                run_pulse;
    logic                clear_pulse;

    assign raw_n = {bus.Clear_n_raw, bus.Run_n_raw};

    // Released buttons read high, so the synchronizers come out of reset released.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_n  <= 2'b11;
            sync_n  <= 2'b11;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            meta_n  <= raw_n;
            sync_n  <= meta_n;
            sw_meta <= bus.Sw_raw;
            sw_sync <= sw_meta;
        end
    end

    assign pressed = ~sync_n;

    for (genvar i = 0; i < 2; i++) begin : g_debounce
        logic          stable_q;
        logic [CW-1:0] count_q;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                stable_q <= 1'b0;
                count_q  <= '0;
            end else if (pressed[i] == stable_q) begin
                count_q <= '0;
            end else if (count_q == CNT_MAX) begin
                stable_q <= pressed[i];
                count_q  <= '0;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end

        assign stable[i] = stable_q;
        // Accepted press happening at this edge; lets the strobe rise with the level.
        assign rise[i]   = pressed[i] & ~stable_q & (count_q == CNT_MAX);
    end

    // Clear wins a tie with Run; a Run press accepted while Busy is dropped, not queued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_pulse   <= 1'b0;
            clear_pulse <= 1'b0;
            sw_hold     <= '0;
        end else begin
            clear_pulse <= rise[1];
            run_pulse   <= rise[0] & ~bus.Busy & ~rise[1];
            if (rise[1]) begin
                sw_hold <= sw_sync;
            end
        end
    end

    assign bus.Run_pulse   = run_pulse;
    assign bus.Clear_pulse = clear_pulse;
    assign bus.Run_level   = stable[0];
    assign bus.Clear_level = stable[1];
    assign bus.Sw_sync     = sw_sync;
    assign bus.Sw_hold     = sw_hold;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: vector table, timed corner sequences, and a random
// run checked every cycle against a sample-history reference model.
module tb_input_conditioner;
    localparam int N = 4;
    localparam int W = 8;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    input_conditioner_if #(.SW_WIDTH(W)) bus ();

    input_conditioner #(.DEBOUNCE_CYCLES(N), .SW_WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: a button is accepted once its last N synchronized samples all
    // differ from the accepted state; history restarts after each acceptance.
    bit             m_rs[2];
    bit             m_cs[2];
    logic [W-1:0]   m_sw[2];
    bit             m_stab_r, m_stab_c;
    bit             h_r[$];
    bit             h_c[$];
    bit             m_pr, m_pc;
    logic [W-1:0]   m_hold;

    function automatic bit window_differs(input bit q[$], input bit stab);
        if (q.size() < N) return 1'b0;
        for (int k = q.size() - N; k < q.size(); k++)
            if (q[k] == stab) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge Clk) begin : model
        bit pr, pc, acc_r, acc_c;
        if (Reset) begin
            m_rs[0] = 1'b1; m_rs[1] = 1'b1;
            m_cs[0] = 1'b1; m_cs[1] = 1'b1;
            m_sw[0] = '0;   m_sw[1] = '0;
            m_stab_r = 1'b0; m_stab_c = 1'b0;
            h_r.delete(); h_c.delete();
            m_pr = 1'b0; m_pc = 1'b0;
            m_hold = '0;
        end else begin
            pr = !m_rs[1];
            pc = !m_cs[1];
            h_r.push_back(pr);
            if (h_r.size() > N) void'(h_r.pop_front());
            h_c.push_back(pc);
            if (h_c.size() > N) void'(h_c.pop_front());
            acc_r = window_differs(h_r, m_stab_r);
            acc_c = window_differs(h_c, m_stab_c);
            if (acc_r) begin m_stab_r = pr; h_r.delete(); end
            if (acc_c) begin m_stab_c = pc; h_c.delete(); end
            m_pc = acc_c && pc;
            m_pr = acc_r && pr && !bus.Busy && !m_pc;
            if (m_pc) m_hold = m_sw[1];
            m_rs[1] = m_rs[0]; m_rs[0] = bus.Run_n_raw;
            m_cs[1] = m_cs[0]; m_cs[0] = bus.Clear_n_raw;
            m_sw[1] = m_sw[0]; m_sw[0] = bus.Sw_raw;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            tests++;
            if (bus.Run_pulse !== m_pr || bus.Clear_pulse !== m_pc ||
                bus.Run_level !== m_stab_r || bus.Clear_level !== m_stab_c ||
                bus.Sw_sync !== m_sw[1] || bus.Sw_hold !== m_hold) begin
                fails++;
                $display("FAIL model t=%0t got rp=%0b cp=%0b rl=%0b cl=%0b ss=%h sh=%h want rp=%0b cp=%0b rl=%0b cl=%0b ss=%h sh=%h",
                         $time, bus.Run_pulse, bus.Clear_pulse, bus.Run_level, bus.Clear_level,
                         bus.Sw_sync, bus.Sw_hold, m_pr, m_pc, m_stab_r, m_stab_c, m_sw[1], m_hold);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    typedef struct {
        bit         run_n;
        bit         clear_n;
        bit         busy;
        logic [7:0] sw;
        int         steps;
        int         exp_rp;
        int         exp_cp;
        bit         exp_rl;
        bit         exp_cl;
        logic [7:0] exp_hold;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int rp_cnt, cp_cnt, len_r, len_c;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00,  8, 0, 0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 60, 1, 0, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 12, 0, 0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 12, 0, 0, 1'b1, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 12, 0, 0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 12, 1, 0, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 12, 0, 0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 12, 0, 1, 1'b0, 1'b1, 8'hA5};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 12, 0, 0, 1'b0, 1'b0, 8'hA5};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 12, 0, 1, 1'b0, 1'b1, 8'h3C};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h3C, 12, 0, 0, 1'b0, 1'b0, 8'h3C};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h77, 12, 0, 1, 1'b1, 1'b1, 8'h77};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h77, 12, 0, 0, 1'b0, 1'b0, 8'h77};

        bus.Run_n_raw   = 1'b1;
        bus.Clear_n_raw = 1'b1;
        bus.Busy        = 1'b0;
        bus.Sw_raw      = 8'hFF;
        Reset           = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        check("reset Run_pulse",   bus.Run_pulse,   0);
        check("reset Clear_pulse", bus.Clear_pulse, 0);
        check("reset Run_level",   bus.Run_level,   0);
        check("reset Clear_level", bus.Clear_level, 0);
        check("reset Sw_sync",     bus.Sw_sync,     0);
        check("reset Sw_hold",     bus.Sw_hold,     0);
        bus.Sw_raw = 8'h00;
        Reset      = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus.Run_n_raw   = vecs[i].run_n;
            bus.Clear_n_raw = vecs[i].clear_n;
            bus.Busy        = vecs[i].busy;
            bus.Sw_raw      = vecs[i].sw;
            rp_cnt = 0;
            cp_cnt = 0;
            for (int s = 0; s < vecs[i].steps; s++) begin
                @(negedge Clk);
                rp_cnt += int'(bus.Run_pulse);
                cp_cnt += int'(bus.Clear_pulse);
            end
            check($sformatf("vec%0d run_pulses", i),   rp_cnt,          vecs[i].exp_rp);
            check($sformatf("vec%0d clear_pulses", i), cp_cnt,          vecs[i].exp_cp);
            check($sformatf("vec%0d Run_level", i),    bus.Run_level,   vecs[i].exp_rl);
            check($sformatf("vec%0d Clear_level", i),  bus.Clear_level, vecs[i].exp_cl);
            check($sformatf("vec%0d Sw_sync", i),      bus.Sw_sync,     vecs[i].sw);
            check($sformatf("vec%0d Sw_hold", i),      bus.Sw_hold,     vecs[i].exp_hold);
        end

        // Clean press: pulse and level appear after edge N+1 = 5, pulse gone after edge 6.
        bus.Run_n_raw = 1'b0;
        step(5);
        check("clean edge4 Run_level", bus.Run_level, 0);
        check("clean edge4 Run_pulse", bus.Run_pulse, 0);
        step(1);
        check("clean edge5 Run_level", bus.Run_level, 1);
        check("clean edge5 Run_pulse", bus.Run_pulse, 1);
        step(1);
        check("clean edge6 Run_pulse", bus.Run_pulse, 0);
        check("clean edge6 Run_level", bus.Run_level, 1);
        bus.Run_n_raw = 1'b1;
        step(12);

        // Bounce low/high/low/low/high, then steady low.
        rp_cnt = 0;
        for (int b = 0; b < 5; b++) begin
            bus.Run_n_raw = (b == 1 || b == 4);
            @(negedge Clk);
            rp_cnt += int'(bus.Run_pulse);
        end
        bus.Run_n_raw = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge Clk);
            rp_cnt += int'(bus.Run_pulse);
        end
        check("bounce early pulses", rp_cnt, 0);
        step(1);
        check("bounce edge5 Run_pulse", bus.Run_pulse, 1);
        rp_cnt = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge Clk);
            rp_cnt += int'(bus.Run_pulse);
        end
        check("bounce extra pulses", rp_cnt, 0);
        bus.Run_n_raw = 1'b1;
        step(12);

        // Switch hold across a Clear press.
        bus.Sw_raw = 8'hA5;
        step(3);
        bus.Clear_n_raw = 1'b0;
        step(6);
        check("clear edge5 Clear_pulse", bus.Clear_pulse, 1);
        check("clear edge5 Sw_hold",     bus.Sw_hold,     8'hA5);
        step(1);
        check("clear edge6 Clear_pulse", bus.Clear_pulse, 0);
        bus.Sw_raw = 8'h3C;
        step(1);
        check("sw edge0 Sw_sync", bus.Sw_sync, 8'hA5);
        step(1);
        check("sw edge1 Sw_sync", bus.Sw_sync, 8'h3C);
        check("sw edge1 Sw_hold", bus.Sw_hold, 8'hA5);
        bus.Clear_n_raw = 1'b1;
        step(12);

        // Reset mid-count with the button still held afterwards.
        bus.Run_n_raw = 1'b0;
        rp_cnt = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge Clk);
            rp_cnt += int'(bus.Run_pulse);
        end
        Reset = 1'b1;
        step(1);
        rp_cnt += int'(bus.Run_pulse);
        check("midreset pulses",     rp_cnt,          0);
        check("midreset Run_level",  bus.Run_level,   0);
        check("midreset Clear_level", bus.Clear_level, 0);
        check("midreset Clear_pulse", bus.Clear_pulse, 0);
        check("midreset Sw_sync",    bus.Sw_sync,     0);
        check("midreset Sw_hold",    bus.Sw_hold,     0);
        step(1);
        Reset = 1'b0;
        step(5);
        check("postreset edge4 Run_pulse", bus.Run_pulse, 0);
        step(1);
        check("postreset edge5 Run_pulse", bus.Run_pulse, 1);
        check("postreset edge5 Run_level", bus.Run_level, 1);
        bus.Run_n_raw = 1'b1;
        step(12);

        // Random bouncy buttons, Busy, switches and occasional resets.
        len_r = 0;
        len_c = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (len_r == 0) begin
                bus.Run_n_raw = ~bus.Run_n_raw;
                len_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(1, 3));
            end
            len_r--;
            if (len_c == 0) begin
                bus.Clear_n_raw = ~bus.Clear_n_raw;
                len_c = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(1, 3));
            end
            len_c--;
            if ($urandom_range(0, 9) == 0) bus.Busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) bus.Sw_raw = 8'($urandom);
            Reset = ($urandom_range(0, 199) == 0);
            @(negedge Clk);
        end
        Reset = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
